mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single RAMHelper-style memory port between instruction fetch (IF) and the load/store unit (LS).
- Sits between the fetch/LSU logic and the RAMHelper instance in SimTop.
- Translates byte addresses to 64-bit word indices and grants at most one request per cycle.
- Returns each response exactly one cycle after grant; LS has priority, and a starvation guard protects fetch.

Parameters:
PC_START, 64'h8000_0000, base byte address of RAM; word index = (addr - PC_START) >> 3
STARVE_MAX, 4, consecutive blocked fetch cycles after which fetch wins the next conflict (1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_req_valid  in  1  fetch request
if_req_ready  out  1  fetch granted this cycle (combinational)
if_addr  in  64  fetch byte address; bit 2 selects the instruction half
if_resp_valid  out  1  fetch data valid
if_resp_inst  out  32  fetched instruction
ls_req_valid  in  1  load/store request
ls_req_ready  out  1  LS granted this cycle (combinational)
ls_addr  in  64  LS byte address, 8-byte aligned
ls_wen  in  1  1 = store, 0 = load
ls_wdata  in  64  store data
ls_wmask  in  64  bit-expanded store mask
ls_resp_valid  out  1  LS completion
ls_resp_rdata  out  64  load data; 0 for stores
ram_en  out  1  RAM read enable
ram_ridx  out  64  RAM read word index
ram_rdata  in  64  RAM read data, valid the cycle after ram_en
ram_widx  out  64  RAM write word index
ram_wdata  out  64  RAM write data
ram_wmask  out  64  RAM write mask
ram_wen  out  1  RAM write enable
busy  out  1  response pending this cycle

Behaviour:
- Clock is clk; reset is rst: one clock, synchronous, active-high.
- Reset:
  - State goes to NONE and the starvation counter to 0.
  - All registered outputs are 0: if_resp_valid, ls_resp_valid, if_resp_inst, ls_resp_rdata, busy.
  - While rst is high, if_req_ready, ls_req_ready, ram_en and ram_wen are forced to 0.
- Reset mid-operation: any in-flight response is dropped. No resp_valid appears in the cycle after reset deasserts.
- Pending-state register (what was granted last cycle): NONE, IF_RD, LS_RD, LS_WR.
  - Next state = winner of the current cycle, or NONE if there is no grant.
- Grant is possible every cycle, including cycles in which a response is returning. Throughput is 1 transaction per cycle.
- Arbitration, per cycle:
  - Only if valid: grant IF.
  - Only ls valid: grant LS.
  - Both valid: grant LS unless starve_cnt == STARVE_MAX, in which case grant IF.
  - Neither valid: no grant; RAM enables are 0.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) each cycle if_req_valid is high and IF is not granted.
  - Clears on IF grant, or when if_req_valid is low.
- Grant cycle, IF:
  - ram_en = 1, ram_ridx = (if_addr - PC_START) >> 3.
  - Latch if_addr[2] for half selection.
- Grant cycle, LS load:
  - ram_en = 1, ram_ridx from ls_addr.
- Grant cycle, LS store:
  - ram_wen = 1; ram_widx from ls_addr.
  - ram_wdata = ls_wdata, ram_wmask = ls_wmask; ram_en = 0.
- Outputs when no write is granted: ram_widx, ram_wdata and ram_wmask are 0.
- Response cycle (grant + 1):
  - IF_RD: if_resp_valid = 1; if_resp_inst = latched bit2 ? ram_rdata[63:32] : ram_rdata[31:0].
  - LS_RD: ls_resp_valid = 1; ls_resp_rdata = ram_rdata.
  - LS_WR: ls_resp_valid = 1; ls_resp_rdata = 0.
  - Response data is registered alongside valid, one cycle after grant.
- No response backpressure: requesters must accept responses in the cycle they appear.
- busy = 1 whenever state != NONE.
- Address arithmetic is 64-bit modulo 2^64. Addresses below PC_START wrap and are not flagged. ls_addr[2:0] is ignored.
- Read-after-write: a load granted the cycle after a store to the same index returns the stored data. This relies on the RAM write committing at the grant edge.

Test Plan:
- Reset:
  - Hold rst 3 cycles with both requests valid -> ready=0, ram_en=0, ram_wen=0, all resp_valid=0.
  - First cycle after release: IF alone valid gets if_req_ready=1.
- Fetch only:
  - if_addr=0x8000_0004, RAM word 0 = 0x00A0_0513_0000_0093 -> ram_ridx=0 in the grant cycle.
  - Next cycle: if_resp_valid=1, if_resp_inst=0x00A0_0513.
- Back-to-back fetches:
  - if_addr 0x8000_0000 then 0x8000_0008 on consecutive cycles -> grants on consecutive cycles.
  - Responses on the two following cycles; busy=1 across both.
- Store then load:
  - Store 0x8000_0010, wdata=0xDEADBEEF_CAFEF00D, wmask all-ones -> ram_wen=1, ram_widx=2, ls_resp_valid next cycle with rdata=0.
  - Following load of the same address -> ls_resp_rdata=0xDEADBEEF_CAFEF00D.
- Starvation:
  - Both valid continuously, STARVE_MAX=4 -> LS granted cycles 0-3, IF granted cycle 4, LS cycles 5-8, IF cycle 9.
- Reset mid-flight:
  - Grant a load, assert rst the next cycle -> ls_resp_valid stays 0 and state returns to NONE.
  - No stale response after rst deasserts.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, load/store and RAM port bundle of the memory port arbiter
interface mem_port_arbiter_if;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [63:0] if_addr;
    logic        if_resp_valid;
    logic [31:0] if_resp_inst;
    logic        ls_req_valid;
    logic        ls_req_ready;
    logic [63:0] ls_addr;
    logic        ls_wen;
    logic [63:0] ls_wdata;
    logic [63:0] ls_wmask;
    logic        ls_resp_valid;
    logic [63:0] ls_resp_rdata;
    logic        ram_en;
    logic [63:0] ram_ridx;
    logic [63:0] ram_rdata;
    logic [63:0] ram_widx;
    logic [63:0] ram_wdata;
    logic [63:0] ram_wmask;
    logic        ram_wen;
    logic        busy;

    modport master (
        output if_req_valid, if_addr, ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask, ram_rdata,
        input  if_req_ready, if_resp_valid, if_resp_inst, ls_req_ready, ls_resp_valid, ls_resp_rdata,
        input  ram_en, ram_ridx, ram_widx, ram_wdata, ram_wmask, ram_wen, busy
    );

    modport slave (
        input  if_req_valid, if_addr, ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask, ram_rdata,
        output if_req_ready, if_resp_valid, if_resp_inst, ls_req_ready, ls_resp_valid, ls_resp_rdata,
        output ram_en, ram_ridx, ram_widx, ram_wdata, ram_wmask, ram_wen, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one RAM port between fetch and load/store, LS first with fetch starvation guard
module mem_port_arbiter #(
    parameter logic [63:0] PC_START   = 64'h8000_0000,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);
    localparam logic [1:0] ST_NONE  = 2'd0;
    localparam logic [1:0] ST_IF_RD = 2'd1;
    localparam logic [1:0] ST_LS_RD = 2'd2;
    localparam logic [1:0] ST_LS_WR = 2'd3;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0]  state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        half_q, half_d;
    logic        grant_if, grant_ls;
    logic [63:0] if_idx, ls_idx;

    always_comb begin
        if_idx   = (bus.if_addr - PC_START) >> 3;
        ls_idx   = ((bus.ls_addr & ~64'h7) - PC_START) >> 3;
        grant_if = !rst && bus.if_req_valid && (!bus.ls_req_valid || starve_q == STARVE_LIM);
        grant_ls = !rst && bus.ls_req_valid && !grant_if;

        state_d = ST_NONE;
        if (grant_if) begin
            state_d = ST_IF_RD;
        end else if (grant_ls) begin
            state_d = bus.ls_wen ? ST_LS_WR : ST_LS_RD;
        end

        // Counts consecutive cycles fetch was asking but lost; any gap in the request restarts it.
        starve_d = 4'd0;
        if (bus.if_req_valid && !grant_if) begin
            starve_d = (starve_q >= STARVE_LIM) ? STARVE_LIM : starve_q + 4'd1;
        end

        half_d = grant_if ? bus.if_addr[2] : half_q;
    end

    always_comb begin
        bus.if_req_ready = grant_if;
        bus.ls_req_ready = grant_ls;
        bus.ram_en       = grant_if || (grant_ls && !bus.ls_wen);
        bus.ram_ridx     = 64'd0;
        if (grant_if) begin
            bus.ram_ridx = if_idx;
        end else if (grant_ls && !bus.ls_wen) begin
            bus.ram_ridx = ls_idx;
        end
        bus.ram_wen   = grant_ls && bus.ls_wen;
        bus.ram_widx  = bus.ram_wen ? ls_idx       : 64'd0;
        bus.ram_wdata = bus.ram_wen ? bus.ls_wdata : 64'd0;
        bus.ram_wmask = bus.ram_wen ? bus.ls_wmask : 64'd0;

        // RAM data arrives the cycle after grant, so responses are steered straight from ram_rdata.
        bus.if_resp_valid = !rst && state_q == ST_IF_RD;
        bus.if_resp_inst  = 32'd0;
        if (bus.if_resp_valid) begin
            bus.if_resp_inst = half_q ? bus.ram_rdata[63:32] : bus.ram_rdata[31:0];
        end
        bus.ls_resp_valid = !rst && (state_q == ST_LS_RD || state_q == ST_LS_WR);
        bus.ls_resp_rdata = (!rst && state_q == ST_LS_RD) ? bus.ram_rdata : 64'd0;
        bus.busy          = !rst && state_q != ST_NONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_NONE;
            starve_q <= 4'd0;
            half_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            half_q   <= half_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam logic [63:0] PC   = 64'h8000_0000;
    localparam int          SMAX = 4;
    localparam logic        O    = 1'b0;
    localparam logic        I    = 1'b1;
    localparam logic [63:0] Z    = 64'd0;
    localparam logic [63:0] ONES = '1;
    localparam logic [63:0] DW   = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [63:0] PW   = 64'h1111_2222_3333_4444;
    localparam logic [63:0] PM   = 64'h0000_0000_FFFF_FFFF;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [63:0] ia;
        logic        lv;
        logic [63:0] la;
        logic        lw;
        logic [63:0] lwd;
        logic [63:0] lwm;
        logic        e_ir;
        logic        e_lr;
        logic        e_en;
        logic        e_wen;
        logic [63:0] e_ridx;
        logic [63:0] e_widx;
        logic [63:0] e_wdata;
        logic [63:0] e_wmask;
        logic        e_ifv;
        logic [31:0] e_inst;
        logic        e_lsv;
        logic [63:0] e_rdata;
        logic        e_busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ram_init = 1'b1;
    logic [63:0] ram [64];
    logic [63:0] rdata_r;
    logic [63:0] mmem [64];
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.PC_START(PC), .STARVE_MAX(SMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [63:0] init_word(input int i);
        if (i == 0) return 64'h00A0_0513_0000_0093;
        if (i == 1) return 64'h1234_5678_9ABC_DEF0;
        return {32'hC0DE_0000 | 32'(i), 32'hF00D_0000 | 32'(i)};
    endfunction

    // Behavioural RAM: a write commits at the grant edge, read data is registered one cycle later.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
        end else begin
            if (bus.ram_wen)
                ram[bus.ram_widx[5:0]] <= (ram[bus.ram_widx[5:0]] & ~bus.ram_wmask) | (bus.ram_wdata & bus.ram_wmask);
            if (bus.ram_en)
                rdata_r <= ram[bus.ram_ridx[5:0]];
        end
    end
    assign bus.ram_rdata = rdata_r;

    task automatic cmp(input string nm, input int step, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %h want %h", nm, step, act, exp);
    endtask

    task automatic apply(input vec_t v, input string tag, input int step);
        rst              = v.rst;
        bus.if_req_valid = v.iv;
        bus.if_addr      = v.ia;
        bus.ls_req_valid = v.lv;
        bus.ls_addr      = v.la;
        bus.ls_wen       = v.lw;
        bus.ls_wdata     = v.lwd;
        bus.ls_wmask     = v.lwm;
        #5;
        cmp({tag, ".if_req_ready"},  step, 64'(bus.if_req_ready),  64'(v.e_ir));
        cmp({tag, ".ls_req_ready"},  step, 64'(bus.ls_req_ready),  64'(v.e_lr));
        cmp({tag, ".ram_en"},        step, 64'(bus.ram_en),        64'(v.e_en));
        cmp({tag, ".ram_wen"},       step, 64'(bus.ram_wen),       64'(v.e_wen));
        cmp({tag, ".ram_ridx"},      step, bus.ram_ridx,           v.e_ridx);
        cmp({tag, ".ram_widx"},      step, bus.ram_widx,           v.e_widx);
        cmp({tag, ".ram_wdata"},     step, bus.ram_wdata,          v.e_wdata);
        cmp({tag, ".ram_wmask"},     step, bus.ram_wmask,          v.e_wmask);
        cmp({tag, ".if_resp_valid"}, step, 64'(bus.if_resp_valid), 64'(v.e_ifv));
        cmp({tag, ".if_resp_inst"},  step, 64'(bus.if_resp_inst),  64'(v.e_inst));
        cmp({tag, ".ls_resp_valid"}, step, 64'(bus.ls_resp_valid), 64'(v.e_lsv));
        cmp({tag, ".ls_resp_rdata"}, step, bus.ls_resp_rdata,      v.e_rdata);
        cmp({tag, ".busy"},          step, 64'(bus.busy),          64'(v.e_busy));
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t idle_vec(input logic r);
        vec_t v;
        v = '{r, O, Z, O, Z, O, Z, Z, O, O, O, O, Z, Z, Z, Z, O, 32'd0, O, Z, O};
        return v;
    endfunction

    vec_t tbl [19];

    initial begin
        vec_t v;
        int   starve;
        logic pend_if, pend_ls;
        logic [63:0] pend_data;

        bus.if_req_valid = 1'b0; bus.if_addr = '0; bus.ls_req_valid = 1'b0; bus.ls_addr = '0;
        bus.ls_wen = 1'b0; bus.ls_wdata = '0; bus.ls_wmask = '0;
        @(posedge clk);
        #1;
        ram_init = 1'b0;

        //          rst iv  ia            lv  la       lw  lwd lwm   ir lr en wen ridx                 widx   wdata wmask ifv inst           lsv rdata                        busy
        tbl[0]  = '{I, I, PC,           I, PC+8,    O, Z,  Z,    O, O, O, O, Z,                    Z,     Z,  Z,    O, 32'd0,         O, Z,                           O};
        tbl[1]  = tbl[0];
        tbl[2]  = tbl[0];
        tbl[3]  = '{O, I, PC+4,         O, Z,       O, Z,  Z,    I, O, I, O, Z,                    Z,     Z,  Z,    O, 32'd0,         O, Z,                           O};
        tbl[4]  = '{O, O, Z,            O, Z,       O, Z,  Z,    O, O, O, O, Z,                    Z,     Z,  Z,    I, 32'h00A0_0513, O, Z,                           I};
        tbl[5]  = '{O, I, PC,           O, Z,       O, Z,  Z,    I, O, I, O, Z,                    Z,     Z,  Z,    O, 32'd0,         O, Z,                           O};
        tbl[6]  = '{O, I, PC+8,         O, Z,       O, Z,  Z,    I, O, I, O, 64'd1,                Z,     Z,  Z,    I, 32'h0000_0093, O, Z,                           I};
        tbl[7]  = '{O, O, Z,            O, Z,       O, Z,  Z,    O, O, O, O, Z,                    Z,     Z,  Z,    I, 32'h9ABC_DEF0, O, Z,                           I};
        tbl[8]  = '{O, O, Z,            I, PC+16,   I, DW, ONES, O, I, O, I, Z,                    64'd2, DW, ONES, O, 32'd0,         O, Z,                           O};
        tbl[9]  = '{O, O, Z,            I, PC+16,   O, Z,  Z,    O, I, I, O, 64'd2,                Z,     Z,  Z,    O, 32'd0,         I, Z,                           I};
        tbl[10] = '{O, O, Z,            O, Z,       O, Z,  Z,    O, O, O, O, Z,                    Z,     Z,  Z,    O, 32'd0,         I, DW,                          I};
        tbl[11] = idle_vec(O);
        tbl[12] = '{O, O, Z,            I, PC+19,   I, PW, PM,   O, I, O, I, Z,                    64'd2, PW, PM,   O, 32'd0,         O, Z,                           O};
        tbl[13] = '{O, O, Z,            I, PC+21,   O, Z,  Z,    O, I, I, O, 64'd2,                Z,     Z,  Z,    O, 32'd0,         I, Z,                           I};
        tbl[14] = '{O, O, Z,            O, Z,       O, Z,  Z,    O, O, O, O, Z,                    Z,     Z,  Z,    O, 32'd0,         I, 64'hDEAD_BEEF_3333_4444,     I};
        tbl[15] = '{O, I, PC,           I, PC+24,   O, Z,  Z,    O, I, I, O, 64'd3,                Z,     Z,  Z,    O, 32'd0,         O, Z,                           O};
        tbl[16] = '{O, I, 64'h7FFF_FFF8, O, Z,      O, Z,  Z,    I, O, I, O, 64'h1FFF_FFFF_FFFF_FFFF, Z,  Z,  Z,    O, 32'd0,         I, 64'hC0DE_0003_F00D_0003,     I};
        tbl[17] = '{O, O, Z,            O, Z,       O, Z,  Z,    O, O, O, O, Z,                    Z,     Z,  Z,    I, 32'hF00D_003F, O, Z,                           I};
        tbl[18] = idle_vec(O);

        for (int k = 0; k < 19; k++) apply(tbl[k], "table", k);

        // Both requesters hold valid: LS wins until fetch has lost STARVE_MAX times in a row.
        apply(idle_vec(I), "starve_rst", 0);
        for (int c = 0; c < 10; c++) begin
            logic gif;
            gif = (c == 4) || (c == 9);
            v = idle_vec(O);
            v.iv = I; v.ia = PC; v.lv = I; v.la = PC + 24;
            v.e_ir = gif; v.e_lr = !gif; v.e_en = I; v.e_ridx = gif ? Z : 64'd3;
            if (c > 0) begin
                v.e_busy = I;
                if (c == 5) begin v.e_ifv = I; v.e_inst = 32'h0000_0093; end
                else begin v.e_lsv = I; v.e_rdata = 64'hC0DE_0003_F00D_0003; end
            end
            apply(v, "starve", c);
        end
        v = idle_vec(O); v.e_ifv = I; v.e_inst = 32'h0000_0093; v.e_busy = I;
        apply(v, "starve_tail", 10);

        // A granted load is dropped when reset hits in its response cycle.
        v = idle_vec(O); v.lv = I; v.la = PC + 24; v.e_lr = I; v.e_en = I; v.e_ridx = 64'd3;
        apply(v, "midrst_grant", 0);
        v = idle_vec(I); v.iv = I; v.ia = PC; v.lv = I; v.la = PC;
        apply(v, "midrst_hold", 1);
        apply(idle_vec(O), "midrst_after", 2);
        apply(idle_vec(O), "midrst_after", 3);

        // Randomised traffic against a transaction-level model with its own copy of memory.
        ram_init = 1'b1;
        apply(idle_vec(I), "rand_rst", 0);
        ram_init = 1'b0;
        for (int i = 0; i < 64; i++) mmem[i] = init_word(i);
        starve = 0; pend_if = 1'b0; pend_ls = 1'b0; pend_data = '0;
        for (int k = 0; k < 500; k++) begin
            int   fidx, lidx;
            logic gif, gls;
            logic [7:0] mb;
            v = idle_vec(O);
            fidx = $urandom_range(0, 63);
            lidx = $urandom_range(0, 63);
            mb   = 8'($urandom);
            v.rst = ($urandom_range(0, 39) == 0);
            v.iv  = ($urandom_range(0, 9) < 6);
            v.ia  = PC + 64'(fidx) * 8 + 64'($urandom_range(0, 1)) * 4;
            v.lv  = ($urandom_range(0, 9) < 6);
            v.la  = PC + 64'(lidx) * 8 + 64'($urandom_range(0, 7));
            v.lw  = $urandom_range(0, 1) == 1;
            v.lwd = {32'($urandom), 32'($urandom)};
            for (int b = 0; b < 8; b++) v.lwm[b*8 +: 8] = {8{mb[b]}};
            if (v.rst) begin
                starve = 0; pend_if = 1'b0; pend_ls = 1'b0;
            end else begin
                v.e_ifv   = pend_if;
                v.e_inst  = pend_if ? pend_data[31:0] : 32'd0;
                v.e_lsv   = pend_ls;
                v.e_rdata = pend_ls ? pend_data : Z;
                v.e_busy  = pend_if || pend_ls;
                gif = v.iv && (!v.lv || starve == SMAX);
                gls = v.lv && !gif;
                starve = (v.iv && !gif) ? ((starve + 1 > SMAX) ? SMAX : starve + 1) : 0;
                pend_if = gif; pend_ls = gls; pend_data = '0;
                v.e_ir = gif; v.e_lr = gls;
                if (gif) begin
                    v.e_en = I; v.e_ridx = 64'(fidx);
                    pend_data[31:0] = v.ia[2] ? mmem[fidx][63:32] : mmem[fidx][31:0];
                end else if (gls && v.lw) begin
                    v.e_wen = I; v.e_widx = 64'(lidx); v.e_wdata = v.lwd; v.e_wmask = v.lwm;
                    mmem[lidx] = (mmem[lidx] & ~v.lwm) | (v.lwd & v.lwm);
                end else if (gls) begin
                    v.e_en = I; v.e_ridx = 64'(lidx);
                    pend_data = mmem[lidx];
                end
            end
            apply(v, "rand", k);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
